cnt_seq_arb: RTL and testbench

Sequencer and two-port arbiter for the team's shared synchronous up/down counter with parallel load. Two requesters each ask for a counting run: start value, stop value and direction. The block grants the counter to one of them at a time in round-robin order. It drives the counter's load, up/down and data inputs so the counter loads the start value, steps to the stop value and then holds there. It sits between the requesters and the counter, and reads the counter's count output back.

---
 rtl/cnt_seq_arb.sv | 131 +++++++++++++
 tb/tb_cnt_seq_arb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_seq_arb.sv
// Round-robin sequencer for the shared up/down counter: grants one requester,
// loads its start value, steps to its stop value. Optional timeout: CNT_SEQ_TIMEOUT_EN.
module cnt_seq_arb #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] start0,
    input  logic [WIDTH-1:0] start1,
    input  logic [WIDTH-1:0] stop0,
    input  logic [WIDTH-1:0] stop1,
    input  logic             dir0,
    input  logic             dir1,
    output logic [1:0]       grant,
    output logic [1:0]       done,
    output logic             err,
    output logic             busy,
    input  logic [WIDTH-1:0] count,
    output logic             load,
    output logic             up_down,
    output logic [WIDTH-1:0] data
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] start_q, stop_q;
    logic             dir_q;
    logic             rr_ptr;
    logic             win1;
    logic             match;
    logic             tmo;

    // requester 1 wins when alone, or when both ask and the pointer favours it
    assign win1  = req1 & (~req0 | rr_ptr);
    assign match = (count == stop_q);

`ifdef CNT_SEQ_TIMEOUT_EN
    localparam logic [WIDTH:0] TMO_LAST = {1'b1, {WIDTH{1'b0}}};
    logic [WIDTH:0] rcnt;

    assign tmo = (state == RUN) && !match && (rcnt == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt <= '0;
            err  <= 1'b0;
        end else begin
            err <= tmo;
            if (state == LOAD)
                rcnt <= '0;
            else if (state == RUN)
                rcnt <= rcnt + 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (req0 | req1) state_nx = LOAD;
            LOAD: state_nx = RUN;
            RUN:  if (match || tmo) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= '0;
            start_q <= '0;
            stop_q  <= '0;
            dir_q   <= 1'b0;
            rr_ptr  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && (req0 | req1)) begin
                grant   <= win1 ? 2'b10 : 2'b01;
                start_q <= win1 ? start1 : start0;
                stop_q  <= win1 ? stop1 : stop0;
                dir_q   <= win1 ? dir1 : dir0;
                rr_ptr  <= ~win1;
            end else if (state == DONE) begin
                grant <= '0;
            end
        end
    end

    // counter controls are forced quiet while reset is asserted
    always_comb begin
        load    = 1'b0;
        up_down = 1'b0;
        data    = '0;
        if (!rst) begin
            unique case (state)
                IDLE, DONE: begin
                    load = 1'b1;
                    data = count;
                end
                LOAD: begin
                    load    = 1'b1;
                    data    = start_q;
                    up_down = dir_q;
                end
                RUN: begin
                    if (match || tmo) begin
                        load = 1'b1;
                        data = count;
                    end else begin
                        up_down = dir_q;
                    end
                end
                default: begin
                    load = 1'b1;
                    data = count;
                end
            endcase
        end
    end

    assign done = (state == DONE) ? grant : 2'b00;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_cnt_seq_arb.sv
// Bench for cnt_seq_arb: behavioural counter, directed table, corner sequences
// and randomized transactions checked against a transaction-level model.
module tb_cnt_seq_arb;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1, dir0, dir1;
    logic [W-1:0] start0, start1, stop0, stop1;
    logic [1:0]   grant, done;
    logic         err, busy, load, up_down;
    logic [W-1:0] count, data;

    logic [W-1:0] cnt_r;
    logic         stuck;

    int   checks = 0;
    int   errors = 0;
    logic model_rr;

    typedef struct {
        logic       r0, r1;
        logic [3:0] s0, p0;
        logic       d0;
        logic [3:0] s1, p1;
        logic       d1;
        logic [1:0] eg;
        int         n;
    } vec_t;

    vec_t tbl[4];

    always #5 clk = ~clk;

    cnt_seq_arb #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .start0(start0), .start1(start1),
        .stop0(stop0), .stop1(stop1),
        .dir0(dir0), .dir1(dir1),
        .grant(grant), .done(done), .err(err), .busy(busy),
        .count(count), .load(load), .up_down(up_down), .data(data)
    );

    // the shared counter: parallel load, otherwise step up or down
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          cnt_r <= '0;
        else if (load)    cnt_r <= data;
        else if (up_down) cnt_r <= cnt_r + 1'b1;
        else              cnt_r <= cnt_r - 1'b1;
    end
    assign count = stuck ? 4'd5 : cnt_r;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_cnt(input int s, input logic d, input int k);
        return d ? (s + k) % 16 : (s - k + 256) % 16;
    endfunction

    function automatic int steps(input int s, input int p, input logic d);
        return d ? (p - s + 16) % 16 : (s - p + 16) % 16;
    endfunction

    function automatic logic [1:0] pick(input logic r0, input logic r1, input logic rr);
        if (r0 && !r1) return 2'b01;
        if (r1 && !r0) return 2'b10;
        return rr ? 2'b10 : 2'b01;
    endfunction

    task automatic do_reset();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        model_rr = 1'b0;
        @(negedge clk);
    endtask

    // entered at a negedge with the DUT idle; returns at the negedge of the following IDLE cycle
    task automatic run_txn(input vec_t v, input logic garble);
        int   s, p;
        logic d;
        s = v.eg[1] ? int'(v.s1) : int'(v.s0);
        p = v.eg[1] ? int'(v.p1) : int'(v.p0);
        d = v.eg[1] ? v.d1 : v.d0;
        req0 = v.r0; req1 = v.r1;
        start0 = v.s0; stop0 = v.p0; dir0 = v.d0;
        start1 = v.s1; stop1 = v.p1; dir1 = v.d1;
        @(negedge clk);
        chk("load_grant", int'(grant), int'(v.eg));
        chk("load_busy", int'(busy), 1);
        chk("load_load", int'(load), 1);
        chk("load_data", int'(data), s);
        chk("load_dir", int'(up_down), int'(d));
        if (garble) begin
            req0 = 1'($urandom); req1 = 1'($urandom);
            start0 = 4'($urandom); stop0 = 4'($urandom); dir0 = 1'($urandom);
            start1 = 4'($urandom); stop1 = 4'($urandom); dir1 = 1'($urandom);
        end
        for (int k = 0; k <= v.n; k++) begin
            @(negedge clk);
            chk("run_count", int'(count), exp_cnt(s, d, k));
            chk("run_grant", int'(grant), int'(v.eg));
            chk("run_done", int'(done), 0);
            chk(k == v.n ? "match_load" : "step_load", int'(load), (k == v.n) ? 1 : 0);
        end
        @(negedge clk);
        chk("done_pulse", int'(done), int'(v.eg));
        chk("done_err", int'(err), 0);
        chk("done_load", int'(load), 1);
        chk("done_count", int'(count), p);
        @(negedge clk);
        chk("idle_grant", int'(grant), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("idle_count", int'(count), p);
        model_rr = (v.eg == 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        tbl[0] = '{r0:1'b1, r1:1'b0, s0:4'd3,  p0:4'd7,  d0:1'b1, s1:4'd0,  p1:4'd0,  d1:1'b0, eg:2'b01, n:4};
        tbl[1] = '{r0:1'b0, r1:1'b1, s0:4'd5,  p0:4'd5,  d0:1'b0, s1:4'd14, p1:4'd1,  d1:1'b1, eg:2'b10, n:3};
        tbl[2] = '{r0:1'b0, r1:1'b1, s0:4'd8,  p0:4'd0,  d0:1'b1, s1:4'd2,  p1:4'd13, d1:1'b0, eg:2'b10, n:5};
        tbl[3] = '{r0:1'b1, r1:1'b0, s0:4'd9,  p0:4'd9,  d0:1'b1, s1:4'd4,  p1:4'd6,  d1:1'b1, eg:2'b01, n:0};

        rst = 1'b1; stuck = 1'b1;
        req0 = 1'b0; req1 = 1'b0; dir0 = 1'b0; dir1 = 1'b0;
        start0 = '0; start1 = '0; stop0 = '0; stop1 = '0;
        model_rr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_load", int'(load), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_updown", int'(up_down), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        stuck = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_hold_load", int'(load), 1);
        chk("idle_hold_dir", int'(up_down), 0);
        chk("idle_hold_data", int'(data), 0);

        for (int i = 0; i < 4; i++) run_txn(tbl[i], 1'b1);

        // both requesters held high from reset: 01, 10, 01
        do_reset();
        v = '{r0:1'b1, r1:1'b1, s0:4'd1, p0:4'd2, d0:1'b1, s1:4'd6, p1:4'd4, d1:1'b0, eg:2'b01, n:1};
        run_txn(v, 1'b0);
        v.eg = 2'b10; v.n = 2;
        run_txn(v, 1'b0);
        v.eg = 2'b01; v.n = 1;
        run_txn(v, 1'b0);

        // reset in the third RUN cycle; pointer must return to requester 0
        do_reset();
        v = '{r0:1'b1, r1:1'b0, s0:4'd4, p0:4'd4, d0:1'b0, s1:4'd0, p1:4'd0, d1:1'b0, eg:2'b01, n:0};
        run_txn(v, 1'b0);
        req0 = 1'b1; start0 = 4'd0; stop0 = 4'd10; dir0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_grant", int'(grant), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_load", int'(load), 0);
        chk("midrst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        model_rr = 1'b0;
        @(negedge clk);
        chk("postrst_load", int'(load), 1);
        chk("postrst_dir", int'(up_down), 0);
        chk("postrst_data", int'(data), 0);
        v = '{r0:1'b1, r1:1'b1, s0:4'd12, p0:4'd15, d0:1'b1, s1:4'd3, p1:4'd1, d1:1'b0, eg:2'b01, n:3};
        run_txn(v, 1'b1);

        // counter stuck at 5 while the run waits for 8
        do_reset();
        stuck = 1'b1;
        req0 = 1'b1; start0 = 4'd2; stop0 = 4'd8; dir0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        chk("tmo_grant", int'(grant), 1);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 16) begin
                chk("tmo_pre_err", int'(err), 0);
                chk("tmo_pre_load", int'(load), 0);
            end
        end
`ifdef CNT_SEQ_TIMEOUT_EN
        chk("tmo_last_load", int'(load), 1);
        @(negedge clk);
        chk("tmo_err", int'(err), 1);
        chk("tmo_done", int'(done), 1);
        @(negedge clk);
        chk("tmo_err_clear", int'(err), 0);
        chk("tmo_idle", int'(busy), 0);
`else
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("notmo_busy", int'(busy), 1);
            chk("notmo_err", int'(err), 0);
            chk("notmo_done", int'(done), 0);
        end
`endif
        stuck = 1'b0;

        // randomized transactions against the round-robin / modular-step model
        do_reset();
        for (int i = 0; i < 40; i++) begin
            int r;
            r = int'($urandom_range(1, 3));
            v.r0 = r[0]; v.r1 = r[1];
            v.s0 = 4'($urandom); v.p0 = 4'($urandom); v.d0 = 1'($urandom);
            v.s1 = 4'($urandom); v.p1 = 4'($urandom); v.d1 = 1'($urandom);
            v.eg = pick(v.r0, v.r1, model_rr);
            v.n  = v.eg[1] ? steps(int'(v.s1), int'(v.p1), v.d1)
                           : steps(int'(v.s0), int'(v.p0), v.d0);
            run_txn(v, 1'b1);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
